// File: rtl/seq_sched_pkg.sv
// Shared types and defaults for sequence_scheduler.
// Holds the FSM state enum, the default parameter values and the burst-length decoder.
package seq_sched_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 3;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // A length field of zero encodes a full sweep of the ROM (2^addr_w words).
    function automatic int len_decode(input int len, input int addr_w);
        return (len == 0) ? (1 << addr_w) : len;
    endfunction

endpackage

// File: rtl/sequence_scheduler_if.sv
// Request/grant and output-stream bundle for sequence_scheduler.
// The master side holds the requesters and the stream consumer. The slave side is the scheduler.
interface sequence_scheduler_if
    import seq_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) ();
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*(ADDR_W+1)-1:0] req_len;
    logic [ADDR_W-1:0]             start_addr;
    logic [NUM_REQ-1:0]            gnt;
    logic [DATA_W-1:0]             out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic                          out_last;

    modport master (
        output req, req_len, start_addr, out_ready,
        input  gnt, out_data, out_valid, out_last
    );

    modport slave (
        input  req, req_len, start_addr, out_ready,
        output gnt, out_data, out_valid, out_last
    );
endinterface

// File: rtl/sequence_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// It searches upward from ptr, wrapping past NUM_REQ-1, and returns a one-hot winner.
module rr_arbiter
    import seq_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               any
);

    logic found;
    int   idx;

    // First asserted request at or after ptr wins; the offset loop provides the wrap.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can leave it holding a value (which would infer a latch).
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/sequence_scheduler.sv
// sequence_scheduler: round-robin sharing of one combinational sequence ROM.
// Each grant streams a burst of ROM words over a valid/ready channel.
// Optional feature: define SEQ_SCHED_TIMEOUT_EN to abort bursts that stall for TIMEOUT cycles (pulses err).
module sequence_scheduler
    import seq_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
`ifdef SEQ_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    sequence_scheduler_if.slave bus,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic                busy,
    output logic                err
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int LEN_W = ADDR_W + 1;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    win_idx_q, win_idx_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                err_q, err_d;

`ifdef SEQ_SCHED_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0]  stall_q, stall_d;
`endif

    logic [NUM_REQ-1:0]  arb_gnt;
    logic                arb_any;
    logic [PTR_W-1:0]    arb_idx;
    logic [LEN_W-1:0]    arb_len;
    logic [PTR_W-1:0]    ptr_next;
    logic                handshake;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req (bus.req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .any (arb_any)
    );

    // Encode the arbiter's one-hot winner so its length slice can be selected and ptr can advance later.
    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) arb_idx = PTR_W'(i);
        end
        arb_len = bus.req_len[arb_idx*LEN_W +: LEN_W];
    end

    // ROM address: start_addr while idle; one word ahead of the current beat during a burst.
    always_comb begin
        rom_addr = (state_q == IDLE) ? bus.start_addr : addr_q + 1'b1;
    end

    assign handshake = out_valid_q && bus.out_ready;
    assign ptr_next  = (win_idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx_q + 1'b1;

    // Next-state logic for the FSM, the burst counters and the output register.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        win_idx_d   = win_idx_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
`ifdef SEQ_SCHED_TIMEOUT_EN
        stall_d     = stall_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    gnt_d       = arb_gnt;
                    win_idx_d   = arb_idx;
                    remaining_d = LEN_W'(len_decode(int'(arb_len), ADDR_W));
                    addr_d      = bus.start_addr;
                    out_data_d  = rom_data;
                    out_valid_d = 1'b1;
                    state_d     = BURST;
`ifdef SEQ_SCHED_TIMEOUT_EN
                    stall_d     = '0;
`endif
                end
            end
            BURST: begin
                if (handshake) begin
`ifdef SEQ_SCHED_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (remaining_q > LEN_W'(1)) begin
                        addr_d      = addr_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        out_data_d  = rom_data;
                    end else begin
                        gnt_d       = '0;
                        out_valid_d = 1'b0;
                        ptr_d       = ptr_next;
                        state_d     = IDLE;
                    end
                end
`ifdef SEQ_SCHED_TIMEOUT_EN
                else if (out_valid_q) begin
                    // The stall that brings the count to TIMEOUT aborts on the same edge.
                    if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                        err_d       = 1'b1;
                        gnt_d       = '0;
                        out_valid_d = 1'b0;
                        ptr_d       = ptr_next;
                        stall_d     = '0;
                        state_d     = IDLE;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; a reset mid-burst drops the burst outright.
    always_ff @(posedge clk) begin
        // NOTE: rst_n is sampled only at the clock edge (synchronous reset), so it is absent from the sensitivity list.
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments, so every flop updates from pre-edge values.
            state_q     <= IDLE;
            gnt_q       <= '0;
            ptr_q       <= '0;
            win_idx_q   <= '0;
            remaining_q <= '0;
            addr_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef SEQ_SCHED_TIMEOUT_EN
            stall_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            win_idx_q   <= win_idx_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
`ifdef SEQ_SCHED_TIMEOUT_EN
            stall_q     <= stall_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = (state_q == BURST) && (remaining_q == LEN_W'(1));
    assign busy          = (state_q != IDLE);
    assign err           = err_q;

endmodule

// File: tb/tb_sequence_scheduler.sv
// Self-checking bench for sequence_scheduler.
// The reference model works at the level of the scheduler's rules: a round-robin pointer, a burst length, and the ROM words expected at start+k.
module tb_sequence_scheduler;
    import seq_sched_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 8;
    localparam int LEN_W   = ADDR_W + 1;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int TIMEOUT = DEF_TIMEOUT;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              busy;
    logic              err;
    logic [DATA_W-1:0] rom [DEPTH];

    sequence_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sequence_scheduler #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy),
        .err      (err)
    );

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int m_ptr    = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int model_winner(input logic [NUM_REQ-1:0] r, input int p);
        for (int off = 0; off < NUM_REQ; off++) begin
            if (r[(p + off) % NUM_REQ]) return (p + off) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one burst from IDLE: grant on the next edge, then L beats with the chosen ready pattern.
    task automatic run_burst(input logic [NUM_REQ-1:0] r, input int start, input int len,
                             input int stall_beat, input int stall_cycles,
                             input bit rand_ready, input bit drop_req);
        int             w;
        int             l;
        int             k;
        int             stalled;
        int             run;
        logic [DATA_W-1:0] q[$];
        logic [15:0]    obs;
        logic [15:0]    exp;
        logic [7:0]     obs_idle;
        w = model_winner(r, m_ptr);
        l = (len == 0) ? DEPTH : len;
        for (int i = 0; i < NUM_REQ; i++) bus.req_len[i*LEN_W +: LEN_W] = LEN_W'($urandom_range(1, 8));
        bus.req_len[w*LEN_W +: LEN_W] = LEN_W'(len);
        bus.req        = r;
        bus.start_addr = ADDR_W'(start);
        bus.out_ready  = 1'b1;
        for (int i = 0; i < l; i++) q.push_back(rom[(start + i) % DEPTH]);
        step();
        k = 0;
        stalled = 0;
        run = 0;
        while (k < l) begin
            obs = {bus.gnt, bus.out_valid, bus.out_last, busy, err, bus.out_data};
            exp = {NUM_REQ'(1 << w), 1'b1, (k == l - 1), 1'b1, 1'b0, q[k]};
            n_checks++;
            if (obs !== exp) $display("FAIL beat %0d of %0d (req %b start %0d): got %h expected %h", k, l, r, start, obs, exp);
            else n_pass++;
            if (k == stall_beat && stalled < stall_cycles) begin
                bus.out_ready = 1'b0;
                stalled++;
            end else if (rand_ready && run < 3 && $urandom_range(0, 2) == 0) begin
                bus.out_ready = 1'b0;
                run++;
            end else begin
                bus.out_ready = 1'b1;
                run = 0;
            end
            if (drop_req && k == 1) bus.req = '0;
            step();
            if (bus.out_ready) k++;
        end
        obs_idle = {bus.gnt, bus.out_valid, bus.out_last, busy, err};
        n_checks++;
        if (obs_idle !== 8'h00) $display("FAIL idle_after_burst (req %b): got %h expected 00", r, obs_idle);
        else n_pass++;
        m_ptr = (w + 1) % NUM_REQ;
        bus.req = '0;
    endtask

    task automatic test_reset();
        logic [19:0] obs;
        logic [19:0] exp;
        rst_n          = 1'b0;
        bus.req        = '0;
        bus.req_len    = '0;
        bus.out_ready  = 1'b0;
        bus.start_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        repeat (3) step();
        obs = {bus.gnt, bus.out_valid, bus.out_last, busy, err, bus.out_data, rom_addr};
        exp = {4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, bus.start_addr};
        n_checks++;
        if (obs !== exp) $display("FAIL reset_values: got %h expected %h", obs, exp);
        else n_pass++;
        rst_n = 1'b1;
        m_ptr = 0;
        step();
    endtask

    task automatic test_single();
        run_burst(4'b0001, 2, 3, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        run_burst(4'b0001, 6, 4, -1, 0, 1'b0, 1'b0);
        run_burst(4'b0001, 5, 0, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_fairness();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_ptr = 0;
        for (int i = 0; i < 5; i++) run_burst(4'b1111, $urandom_range(0, DEPTH - 1), 1, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_burst(4'b0110, 3, 6, 2, 5, 1'b0, 1'b0);
        run_burst(4'b1000, 7, 5, 1, 2, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            run_burst(NUM_REQ'($urandom_range(1, 15)), $urandom_range(0, DEPTH - 1),
                      $urandom_range(0, 8), -1, 0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] obs;
        logic [19:0] exp;
        run_burst(4'b0010, 0, 2, -1, 0, 1'b0, 1'b0);
        bus.req_len[2*LEN_W +: LEN_W] = LEN_W'(5);
        bus.req        = 4'b0100;
        bus.start_addr = 3'd1;
        bus.out_ready  = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        bus.start_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        step();
        obs = {bus.gnt, bus.out_valid, bus.out_last, busy, err, bus.out_data, rom_addr};
        exp = {4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, bus.start_addr};
        n_checks++;
        if (obs !== exp) $display("FAIL reset_mid_burst: got %h expected %h", obs, exp);
        else n_pass++;
        rst_n   = 1'b1;
        bus.req = '0;
        m_ptr   = 0;
        step();
        n_checks++;
        if ({bus.out_valid, busy} !== 2'b00) $display("FAIL no_beat_after_reset: got %b expected 00", {bus.out_valid, busy});
        else n_pass++;
        run_burst(4'b1111, 4, 2, -1, 0, 1'b0, 1'b0);
    endtask

`ifdef SEQ_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int          w;
        logic [7:0]  obs;
        logic [7:0]  exp;
        w = model_winner(4'b0011, m_ptr);
        for (int i = 0; i < NUM_REQ; i++) bus.req_len[i*LEN_W +: LEN_W] = LEN_W'(3);
        bus.req        = 4'b0011;
        bus.start_addr = 3'd0;
        bus.out_ready  = 1'b0;
        step();
        for (int i = 1; i < TIMEOUT; i++) begin
            step();
            obs = {bus.gnt, bus.out_valid, bus.out_last, busy, err};
            exp = {NUM_REQ'(1 << w), 1'b1, 1'b0, 1'b1, 1'b0};
            n_checks++;
            if (obs !== exp) $display("FAIL stall_cycle_%0d: got %h expected %h", i, obs, exp);
            else n_pass++;
        end
        step();
        obs = {bus.gnt, bus.out_valid, bus.out_last, busy, err};
        n_checks++;
        if (obs !== 8'h01) $display("FAIL timeout_abort: got %h expected 01", obs);
        else n_pass++;
        m_ptr = (w + 1) % NUM_REQ;
        run_burst(4'b0011, 0, 3, -1, 0, 1'b0, 1'b0);
    endtask
`else
    task automatic test_long_stall();
        run_burst(4'b0001, 2, 3, 1, 20, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = DATA_W'($urandom_range(0, 255));
        test_reset();
        test_single();
        test_wrap();
        test_fairness();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef SEQ_SCHED_TIMEOUT_EN
        test_timeout();
`else
        test_long_stall();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sequence_scheduler.md
# sequence_scheduler

Round-robin scheduler that shares one sequence ROM and its output channel between `NUM_REQ` requesters. A granted requester receives a burst of `len` ROM words, starting at a sampled start address, on a valid/ready stream. The block sits between the requesting agents and the combinational `sequence_rom`. It replaces free-running counter sequencing with arbitrated, flow-controlled bursts.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `ADDR_W`, 3, ROM address width
- `DATA_W`, 8, ROM word width
- `TIMEOUT`, 16, stall cycles before abort (only with the macro)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `req`  in  NUM_REQ  request, level-sensitive
- `req_len`  in  NUM_REQ*(ADDR_W+1)  per-requester burst length, slice i for requester i; 0 means 2^ADDR_W
- `start_addr`  in  ADDR_W  first ROM address, sampled at grant
- `gnt`  out  NUM_REQ  one-hot grant, held for the whole burst
- `rom_addr`  out  ADDR_W  address to `sequence_rom`
- `rom_data`  in  DATA_W  combinational ROM data for `rom_addr`
- `out_data`  out  DATA_W  registered burst word
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  consumer accepts the word when high with `out_valid`
- `out_last`  out  1  final beat of the burst
- `busy`  out  1  state != IDLE
- `err`  out  1  one-cycle abort pulse

## Operation
- States: IDLE, BURST.
- **IDLE**
  - If any `req` bit is high, select a winner by round-robin, searching upward from `ptr` (indices wrap).
  - Register the winner's `gnt` bit.
  - Load `remaining` with the decoded `req_len` (0 becomes 2^ADDR_W).
  - Load `addr` with `start_addr`.
  - Capture `rom_data` at address `start_addr` into `out_data`, set `out_valid`, then go to BURST.
  - `rom_addr` = `start_addr` while in IDLE.
- **BURST**
  - `rom_addr` = `addr`+1 (mod 2^ADDR_W).
  - `out_last` = (`remaining`==1).
  - On a handshake with `remaining`>1: `addr`++ (wraps 7→0 for ADDR_W=3), `remaining`--, and `out_data` takes `rom_data`.
  - On a handshake with `remaining`==1: clear `gnt`, `out_valid` and `out_last`; set `ptr` = winner+1 mod NUM_REQ; go to IDLE.
  - With no handshake, all outputs hold.
- Deassertion of `req` mid-burst is ignored; the burst always completes.
- `req` is not sampled in BURST.
- `remaining` width is ADDR_W+1; it never underflows.
- Reset values: `gnt`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `err`=0, `ptr`=0, state IDLE. `rom_addr` follows `start_addr`.
- A low `rst_n` at any edge, including mid-burst, forces reset values at that edge. No partial beat is emitted afterwards.

## Timing
- `req` high at edge N (from IDLE) → `gnt`, `out_valid` and the first word are visible after edge N.
- Zero-wait consumer: one beat per cycle.
- A burst of length L occupies L cycles plus 1 IDLE cycle.
- Last handshake at edge M → IDLE during cycle M→M+1 → next grant at edge M+1.
- There is a minimum one-cycle gap between bursts.
- `out_data`, `out_valid` and `out_last` are stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `SEQ_SCHED_TIMEOUT_EN` defined:
  - A stall counter counts consecutive BURST cycles with `out_valid`=1 and `out_ready`=0.
  - It clears on every handshake.
  - When it reaches `TIMEOUT`, the burst is aborted at that edge: `err` pulses for one cycle, `gnt`/`out_valid` clear, `ptr` advances past the winner, and the state returns to IDLE.
- `SEQ_SCHED_TIMEOUT_EN` undefined: there is no counter, the block waits indefinitely, and `err` is tied 0.

## Structure
- Package `seq_sched_pkg` holds:
  - the state enum (IDLE, BURST)
  - default parameter constants
  - a `len_decode` function (0 → 2^ADDR_W)
- Sub-module `rr_arbiter`: combinational one-hot winner from `req` and `ptr`, with an `any` output. It is instantiated once.
- Counters, the FSM and the output register live in the top module.

## Test plan
- **Single request:** `req`=0001, len=3, `start_addr`=2, `out_ready`=1 → words ROM[2],ROM[3],ROM[4] on 3 consecutive cycles; `out_last` on the third; `gnt`=0001 for exactly 3 cycles.
- **Wrap-around:** `start_addr`=6, len=4 → addresses 6,7,0,1. Then len=0 → 8 beats.
- **Fairness:** `req`=1111 held, len=1 each → grants 0001,0010,0100,1000,0001, each separated by one IDLE cycle.
- **Backpressure:** `out_ready` low for 5 cycles mid-burst → `out_data`/`out_valid`/`out_last` held; the burst resumes intact. Drop `req` mid-burst → the burst still completes.
- **Reset mid-burst:** `rst_n`=0 at beat 2 of 5 → next cycle all outputs at reset values and `ptr`=0.
- **With `SEQ_SCHED_TIMEOUT_EN`:** `out_ready` held low 16 cycles → one-cycle `err`, `gnt` cleared, and the next requester is granted one cycle later.
